// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router: DEPTH x {hdr, byte} FIFO with
// header-tagged entries and a read-side packet-length counter for rd_busy.
module router_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       soft_reset,
   input  logic       write_enb,
   input  logic       read_enb,
   input  logic       lfd_state,
   input  logic [7:0] data_in,
   output logic       full,
   output logic       empty,
   output logic       rd_busy,
   output logic [7:0] data_out
);

   logic [7:0]       r_mem_byte [DEPTH];
   logic [DEPTH-1:0] r_mem_hdr;
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [6:0]       r_rd_cnt;
   logic [7:0]       r_data_out;

   logic             w_do_wr;
   logic             w_do_rd;
   logic             w_flush;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic [7:0]       w_rd_byte;
   logic             w_rd_hdr;
   logic [6:0]       w_hdr_len;

   assign w_wr_idx  = r_wr_ptr[AW-1:0];
   assign w_rd_idx  = r_rd_ptr[AW-1:0];
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_flush   = !resetn || soft_reset;
   assign w_do_wr   = write_enb && !full;
   assign w_do_rd   = read_enb && !empty;
   assign w_rd_byte = r_mem_byte[w_rd_idx];
   assign w_rd_hdr  = r_mem_hdr[w_rd_idx];
   // Header length field plus one for the trailing parity byte.
   assign w_hdr_len = {1'b0, w_rd_byte[7:2]} + 7'd1;

   assign rd_busy   = (r_rd_cnt != 7'd0);
   assign data_out  = r_data_out;

   // Byte storage is never cleared; only the hdr tags and pointers are.
   always_ff @(posedge clock) begin
      if (!w_flush && w_do_wr) begin
         r_mem_byte[w_wr_idx] <= data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (w_flush) begin
         r_mem_hdr <= '0;
         r_wr_ptr  <= '0;
      end else if (w_do_wr) begin
         r_mem_hdr[w_wr_idx] <= lfd_state;
         r_wr_ptr            <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (w_flush) begin
         r_rd_ptr   <= '0;
         r_rd_cnt   <= 7'd0;
         r_data_out <= 8'h00;
      end else if (w_do_rd) begin
         r_rd_ptr   <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
         r_data_out <= w_rd_byte;
         if (w_rd_hdr) begin
            r_rd_cnt <= w_hdr_len;
         end else if (r_rd_cnt != 7'd0) begin
            r_rd_cnt <= r_rd_cnt - 7'd1;
         end
      end
   end

endmodule
